// File: rtl/conv_seq_ctrl.sv
// Sequencer for one output-channel convolution pass on core: kernel load, activation load,
// execute and OFIFO drain per kernel position. Optional OFIFO wait state: CONV_SEQ_OFIFO_WAIT_EN.
module conv_seq_ctrl #(
  parameter int          col       = 8,
  parameter int          row       = 8,
  parameter int          len_nij   = 36,
  parameter int          nij_sz    = 6,
  parameter int          n_kij     = 9,
  parameter int          htiles    = 2,
  parameter logic [10:0] kmem_base = 11'h400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic [1:0]  tile,
  output logic        sel,
  output logic        mode,
  output logic        relu,
  output logic [3:0]  kij_idx,
  output logic        busy,
  output logic        done,
  output logic [3:0]  state_dbg
);

  // Handshake: start is a level sampled only in IDLE; there is no back-pressure toward the host.
  // With the wait option, ofifo_valid acts as a ready-to-drain qualifier seen only in OWAIT.

  typedef enum logic [3:0] {
    S_IDLE,
    S_KLOAD,
    S_KGAP,
    S_ALOAD,
    S_EXEC,
`ifdef CONV_SEQ_OFIFO_WAIT_EN
    S_OWAIT,
`endif
    S_OREAD,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

  localparam int B_ACC = 33, B_CEN_P = 32, B_WEN_P = 31, B_CEN_X = 19, B_WEN_X = 18;
  localparam int B_OFIFO_RD = 6, B_L0_RD = 3, B_L0_WR = 2, B_EXEC = 1, B_LOAD = 0;

  localparam logic [7:0] KW_LAST    = 8'(2 * col - 1);
  localparam logic [7:0] KLOAD_LAST = 8'(2 * col + row);
  localparam logic [7:0] LOAD_LAST  = 8'(2 * col);
  localparam logic [7:0] ALOAD_LAST = 8'(len_nij - 1);
  localparam logic [7:0] EXEC_LAST  = 8'(len_nij + 2 * col - 1);
  localparam logic [7:0] EXEC_ON    = 8'(len_nij);
  localparam logic [7:0] OREAD_LAST = 8'(len_nij);
  localparam logic [7:0] DRAIN_LAST = 8'd1;
  localparam logic [3:0] J_LAST     = 4'(htiles - 1);
  localparam logic [3:0] K_LAST     = 4'(n_kij - 1);

  state_t      state, state_nxt;
  logic [7:0]  c, c_nxt;
  logic [3:0]  j, j_nxt;
  logic [3:0]  kij, kij_nxt;

  logic [33:0] inst_nxt;
  logic [1:0]  tile_nxt;
  logic        sel_nxt, relu_nxt, busy_nxt, done_nxt;
  logic [3:0]  kij_idx_nxt;

  logic [10:0] xmem_kaddr, pmem_off, pmem_addr;

  // Weight rows for (kij, tile) are packed contiguously, 2*col words per tile.
  assign xmem_kaddr = kmem_base + 11'((int'(kij) * htiles + int'(j)) * 2 * col + int'(c));
  assign pmem_off   = 11'(int'(kij) % 3 + (int'(kij) / 3) * nij_sz);
  // Deliberately 11-bit modular: early kij offsets wrap below zero.
  assign pmem_addr  = 11'(c) - 11'd1 - pmem_off;

  always_comb begin
    state_nxt   = state;
    c_nxt       = c + 8'd1;
    j_nxt       = j;
    kij_nxt     = kij;
    inst_nxt    = INST_IDLE;
    tile_nxt    = tile;
    sel_nxt     = kij[0];
    relu_nxt    = 1'b0;
    busy_nxt    = (state != S_IDLE);
    done_nxt    = (state == S_DONE);
    kij_idx_nxt = kij;

    case (state)
      S_IDLE: begin
        c_nxt = '0;
        if (start) begin
          state_nxt = S_KLOAD;
          j_nxt     = '0;
          kij_nxt   = '0;
        end
      end

      S_KLOAD: begin
        tile_nxt = 2'b01 << j;
        if (c <= KW_LAST) begin
          inst_nxt[B_CEN_X] = 1'b0;
          inst_nxt[B_WEN_X] = 1'b1;
          inst_nxt[B_L0_WR] = 1'b1;
          inst_nxt[17:7]    = xmem_kaddr;
        end
        // L0 read trails the write by one cycle; the tail only flushes the PE rows.
        if (c >= 8'd1 && c <= LOAD_LAST) begin
          inst_nxt[B_L0_RD] = 1'b1;
          inst_nxt[B_LOAD]  = 1'b1;
        end else if (c > LOAD_LAST) begin
          inst_nxt[B_L0_RD] = 1'b1;
        end
        if (c == KLOAD_LAST) begin
          state_nxt = S_KGAP;
          c_nxt     = '0;
        end
      end

      S_KGAP: begin
        c_nxt = '0;
        if (j == J_LAST) begin
          state_nxt = S_ALOAD;
          j_nxt     = '0;
        end else begin
          state_nxt = S_KLOAD;
          j_nxt     = j + 4'd1;
        end
      end

      S_ALOAD: begin
        tile_nxt          = 2'b11;
        inst_nxt[B_CEN_X] = 1'b0;
        inst_nxt[B_WEN_X] = 1'b1;
        inst_nxt[B_L0_WR] = 1'b1;
        inst_nxt[17:7]    = 11'(c);
        if (c == ALOAD_LAST) begin
          state_nxt = S_EXEC;
          c_nxt     = '0;
        end
      end

      S_EXEC: begin
        inst_nxt[B_L0_RD] = 1'b1;
        inst_nxt[B_EXEC]  = (c < EXEC_ON);
        if (c == EXEC_LAST) begin
`ifdef CONV_SEQ_OFIFO_WAIT_EN
          state_nxt = S_OWAIT;
`else
          state_nxt = S_OREAD;
`endif
          c_nxt = '0;
        end
      end

`ifdef CONV_SEQ_OFIFO_WAIT_EN
      S_OWAIT: begin
        c_nxt = '0;
        if (ofifo_valid) state_nxt = S_OREAD;
      end
`endif

      S_OREAD: begin
        inst_nxt[B_OFIFO_RD] = 1'b1;
        inst_nxt[B_ACC]      = (kij != 4'd0);
        relu_nxt             = (kij == K_LAST);
        if (c >= 8'd1) begin
          inst_nxt[B_CEN_P] = 1'b0;
          inst_nxt[B_WEN_P] = 1'b0;
          inst_nxt[30:20]   = pmem_addr;
        end
        if (c == OREAD_LAST) begin
          state_nxt = S_DRAIN;
          c_nxt     = '0;
        end
      end

      S_DRAIN: begin
        if (c == DRAIN_LAST) begin
          c_nxt = '0;
          if (kij == K_LAST) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_KLOAD;
            kij_nxt   = kij + 4'd1;
          end
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
        c_nxt     = '0;
      end

      default: begin
        state_nxt = S_IDLE;
        c_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      c       <= '0;
      j       <= '0;
      kij     <= '0;
      inst    <= INST_IDLE;
      tile    <= 2'b01;
      sel     <= 1'b0;
      relu    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      kij_idx <= '0;
    end else begin
      state   <= state_nxt;
      c       <= c_nxt;
      j       <= j_nxt;
      kij     <= kij_nxt;
      inst    <= inst_nxt;
      tile    <= tile_nxt;
      sel     <= sel_nxt;
      relu    <= relu_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      kij_idx <= kij_idx_nxt;
    end
  end

  assign mode      = 1'b0;
  assign state_dbg = state;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: reset state, full-pass timing trace, reset mid-pass,
// and the OFIFO wait option when CONV_SEQ_OFIFO_WAIT_EN is defined.
module tb_conv_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, ofifo_valid;
  logic [33:0] inst;
  logic [1:0]  tile;
  logic        sel, mode, relu, busy, done;
  logic [3:0]  kij_idx, state_dbg;

  int checks = 0;
  int errors = 0;

`ifdef CONV_SEQ_OFIFO_WAIT_EN
  localparam int OW = 1;
`else
  localparam int OW = 0;
`endif
  localparam int PER   = 179 + OW;
  localparam int TOTAL = 9 * PER;
  localparam int R0    = 140 + OW;
  localparam logic [33:0] INST_RST = 34'h1_800C_0000;

  logic [33:0] inst_tr [0:1700];
  logic [1:0]  tile_tr [0:1700];
  logic        sel_tr  [0:1700];
  logic        relu_tr [0:1700];
  logic        busy_tr [0:1700];
  logic        done_tr [0:1700];
  logic [3:0]  kij_tr  [0:1700];

  conv_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .tile(tile), .sel(sel), .mode(mode), .relu(relu),
    .kij_idx(kij_idx), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // After launch() returns, the sampled outputs belong to the first active cycle (t=0).
  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (inst !== INST_RST) begin errors++; $display("FAIL reset_inst: got %h want %h", inst, INST_RST); end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
      checks++;
      if (tile !== 2'b01 || sel !== 1'b0 || relu !== 1'b0 || mode !== 1'b0 || kij_idx !== 4'd0) begin
        errors++; $display("FAIL reset_misc: tile %b sel %b relu %b mode %b kij %0d", tile, sel, relu, mode, kij_idx);
      end
      checks++;
      if (state_dbg !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    end
  endtask

  task automatic test_full_pass();
    int first_done, done_cnt, busy_bad, load_cnt;
    launch();
    for (int t = 0; t <= TOTAL + 2; t++) begin
      inst_tr[t] = inst; tile_tr[t] = tile; sel_tr[t] = sel; relu_tr[t] = relu;
      busy_tr[t] = busy; done_tr[t] = done; kij_tr[t] = kij_idx;
      step();
    end

    first_done = -1; done_cnt = 0; busy_bad = 0;
    for (int t = 0; t <= TOTAL + 2; t++) begin
      if (done_tr[t] === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = t;
      end
      if (t <= TOTAL && busy_tr[t] !== 1'b1) busy_bad++;
    end
    checks++;
    if (first_done != TOTAL) begin errors++; $display("FAIL done_latency: got %0d want %0d", first_done, TOTAL); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL done_width: got %0d want 1", done_cnt); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL busy_window: %0d cycles low want 0", busy_bad); end
    checks++;
    if (busy_tr[TOTAL + 1] !== 1'b0) begin errors++; $display("FAIL busy_drop: got %b want 0", busy_tr[TOTAL + 1]); end
    checks++;
    if (kij_tr[TOTAL + 2] !== 4'd8) begin errors++; $display("FAIL kij_hold: got %0d want 8", kij_tr[TOTAL + 2]); end

    for (int k = 0; k < 9; k++) begin
      checks++;
      if (kij_tr[k * PER] !== 4'(k)) begin errors++; $display("FAIL kij_step: at kij %0d got %0d", k, kij_tr[k * PER]); end
    end

    // kij=0, tile 1 weight load: 11'h410..11'h41F
    checks++;
    if (tile_tr[26] !== 2'b10) begin errors++; $display("FAIL kload_tile: got %b want 10", tile_tr[26]); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (inst_tr[26 + i][17:7] !== 11'(16'h410 + i) || inst_tr[26 + i][2] !== 1'b1 ||
          inst_tr[26 + i][19:18] !== 2'b01) begin
        errors++; $display("FAIL kload_addr: c %0d got A %h wr %b cw %b want A %h", i,
                           inst_tr[26 + i][17:7], inst_tr[26 + i][2], inst_tr[26 + i][19:18], 11'(16'h410 + i));
      end
    end
    load_cnt = 0;
    for (int t = 26; t <= 51; t++) if (inst_tr[t][0] === 1'b1) load_cnt++;
    checks++;
    if (load_cnt != 16) begin errors++; $display("FAIL load_count: got %0d want 16", load_cnt); end
    checks++;
    if (inst_tr[26][0] !== 1'b0 || inst_tr[27][0] !== 1'b1 || inst_tr[42][0] !== 1'b1 || inst_tr[43][0] !== 1'b0) begin
      errors++; $display("FAIL load_lag: got %b%b%b%b want 0110", inst_tr[26][0], inst_tr[27][0], inst_tr[42][0], inst_tr[43][0]);
    end
    checks++;
    if (inst_tr[43][3] !== 1'b1 || inst_tr[50][3] !== 1'b1 || inst_tr[51] !== INST_RST) begin
      errors++; $display("FAIL kload_tail: l0_rd %b %b gap %h", inst_tr[43][3], inst_tr[50][3], inst_tr[51]);
    end

    checks++;
    if (tile_tr[52] !== 2'b11 || inst_tr[52][17:7] !== 11'd0 || inst_tr[52][2] !== 1'b1 || inst_tr[87][17:7] !== 11'd35) begin
      errors++; $display("FAIL aload: tile %b A0 %h wr %b A35 %h", tile_tr[52], inst_tr[52][17:7], inst_tr[52][2], inst_tr[87][17:7]);
    end
    checks++;
    if (inst_tr[88][1] !== 1'b1 || inst_tr[123][1] !== 1'b1 || inst_tr[124][1] !== 1'b0 || inst_tr[139][3] !== 1'b1) begin
      errors++; $display("FAIL exec: ex %b %b %b rd %b want 1101", inst_tr[88][1], inst_tr[123][1], inst_tr[124][1], inst_tr[139][3]);
    end

    checks++;
    if (inst_tr[R0][6] !== 1'b1 || inst_tr[R0][32] !== 1'b1) begin
      errors++; $display("FAIL oread_c0: rd %b cen %b want 11", inst_tr[R0][6], inst_tr[R0][32]);
    end
    for (int i = 0; i < 36; i++) begin
      checks++;
      if (inst_tr[R0 + 1 + i][30:20] !== 11'(i) || inst_tr[R0 + 1 + i][32:31] !== 2'b00 ||
          inst_tr[R0 + 1 + i][33] !== 1'b0 || relu_tr[R0 + 1 + i] !== 1'b0) begin
        errors++; $display("FAIL oread_k0: i %0d got A %h cw %b acc %b relu %b", i, inst_tr[R0 + 1 + i][30:20],
                           inst_tr[R0 + 1 + i][32:31], inst_tr[R0 + 1 + i][33], relu_tr[R0 + 1 + i]);
      end
    end
    checks++;
    if (inst_tr[R0 + 37] !== INST_RST) begin errors++; $display("FAIL drain: got %h want %h", inst_tr[R0 + 37], INST_RST); end
    checks++;
    if (sel_tr[PER + R0] !== 1'b1 || inst_tr[PER + R0][33] !== 1'b1) begin
      errors++; $display("FAIL k1_sel_acc: sel %b acc %b want 11", sel_tr[PER + R0], inst_tr[PER + R0][33]);
    end
    checks++;
    if (inst_tr[8 * PER + R0 + 1][30:20] !== 11'h7F2 || inst_tr[8 * PER + R0 + 36][30:20] !== 11'h015) begin
      errors++; $display("FAIL k8_addr: first %h last %h want 7f2 015",
                         inst_tr[8 * PER + R0 + 1][30:20], inst_tr[8 * PER + R0 + 36][30:20]);
    end
    checks++;
    if (inst_tr[8 * PER + R0 + 1][33] !== 1'b1 || relu_tr[8 * PER + R0 + 1] !== 1'b1 || sel_tr[8 * PER + R0 + 1] !== 1'b0) begin
      errors++; $display("FAIL k8_flags: acc %b relu %b sel %b want 110",
                         inst_tr[8 * PER + R0 + 1][33], relu_tr[8 * PER + R0 + 1], sel_tr[8 * PER + R0 + 1]);
    end
  endtask

  task automatic test_reset_mid();
    launch();
    repeat (4 * PER + 98) step();
    reset = 1'b1;
    step();
    checks++;
    if (inst !== INST_RST || busy !== 1'b0 || tile !== 2'b01 || kij_idx !== 4'd0 || relu !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset_out: inst %h busy %b tile %b kij %0d", inst, busy, tile, kij_idx);
    end
    checks++;
    if (state_dbg !== 4'd0) begin errors++; $display("FAIL mid_reset_state: got %0d want 0", state_dbg); end
    reset = 1'b0;
    step();
    checks++;
    if (inst !== INST_RST || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_hold: inst %h busy %b", inst, busy); end
    launch();
    checks++;
    if (busy !== 1'b1 || kij_idx !== 4'd0 || inst[17:7] !== 11'h400 || inst[2] !== 1'b1 || tile !== 2'b01) begin
      errors++; $display("FAIL restart: busy %b kij %0d A %h wr %b tile %b want 1 0 400 1 01", busy, kij_idx, inst[17:7], inst[2], tile);
    end
    do_reset();
    step();
  endtask

`ifdef CONV_SEQ_OFIFO_WAIT_EN
  task automatic test_owait();
    int bad;
    ofifo_valid = 1'b0;
    launch();
    repeat (140) step();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (inst[6] !== 1'b0 || inst[32] !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL owait_hold: %0d cycles with strobes want 0", bad); end
    ofifo_valid = 1'b1;
    step();
    checks++;
    if (inst[6] !== 1'b0) begin errors++; $display("FAIL owait_exit_early: rd %b want 0", inst[6]); end
    step();
    checks++;
    if (inst[6] !== 1'b1 || inst[32] !== 1'b1) begin errors++; $display("FAIL owait_oread: rd %b cen %b want 11", inst[6], inst[32]); end
    step();
    checks++;
    if (inst[30:20] !== 11'd0 || inst[32] !== 1'b0) begin errors++; $display("FAIL owait_first_wr: A %h cen %b want 000 0", inst[30:20], inst[32]); end
    do_reset();
    step();
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ofifo_valid = 1'b1;
    test_reset();
    test_full_pass();
    test_reset_mid();
`ifdef CONV_SEQ_OFIFO_WAIT_EN
    test_owait();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
